ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL take parameter ADDRESS_WIDTH, default 14, as the word-address width of the shared 16-bit RAM.
REQ-002 SHALL have one clock and asynchronous active-low reset: clk input 1 (system clock, all state on rising edge); rst_n input 1 (asynchronous, active-low reset).
REQ-003 m0_req input 1: requester 0 has an access pending; held until m0_ack is seen.
REQ-004 m0_we input 2: per-byte write enables for requester 0; bit0 covers [7:0], bit1 covers [15:8]; 2'b00 means read.
REQ-005 m0_addr input ADDRESS_WIDTH: word address for requester 0.
REQ-006 m0_wdata input 16: write data for requester 0.
REQ-007 m0_ack output 1: one-cycle pulse when requester 0's access is issued to RAM.
REQ-008 m0_rvalid output 1: one-cycle pulse when m0_rdata holds read data.
REQ-009 m0_rdata output 16: read data for requester 0.
REQ-010 m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rvalid and m1_rdata SHALL mirror REQ-003..REQ-009 for requester 1.
REQ-011 ram_we output 2: byte write enables to the RAM.
REQ-012 ram_addr output ADDRESS_WIDTH: RAM word address.
REQ-013 ram_data output 16: RAM write data.
REQ-014 ram_q input 16: RAM read data, valid one cycle after the address is sampled.

Function
REQ-015 SHALL implement two states: IDLE and ACCESS.
REQ-016 In IDLE with any req high, SHALL select one requester, register its we/addr/wdata and owner id, and enter ACCESS next cycle; with no req, SHALL stay in IDLE.
REQ-017 In ACCESS, SHALL drive ram_we/ram_addr/ram_data from the registered request, assert the owner's ack for exactly that cycle, and return to IDLE next cycle.
REQ-018 Throughput SHALL be one access per 2 cycles; a requester whose req stays high after its ack SHALL be treated as a new request.
REQ-019 ram_we SHALL be 2'b00 in every cycle other than ACCESS; ram_addr and ram_data SHALL hold their last values outside ACCESS.
REQ-020 For a read (registered we==2'b00), SHALL assert the owner's rvalid in the cycle after ACCESS, with rdata = ram_q in that cycle; total request-to-rvalid latency = 3 cycles.
REQ-021 Writes SHALL produce no rvalid; partial writes (01, 10) SHALL pass to ram_we unchanged.
REQ-022 m*_rdata SHALL hold its last value when rvalid is low; the non-owner's rvalid and ack SHALL stay low.
REQ-023 Arbitration SHALL be round-robin: with both req high in IDLE, the requester not granted most recently wins; with one req high, that requester wins regardless of pointer.
REQ-024 Requests arriving during ACCESS SHALL NOT be granted until the following IDLE cycle.
REQ-025 Both acks SHALL never be high in the same cycle.

Reset
REQ-026 On rst_n low, SHALL immediately enter IDLE and clear all outputs (acks, rvalids, ram_we, ram_addr, ram_data, rdata) to 0.
REQ-027 On rst_n low, the round-robin pointer SHALL favour requester 0 on the first contended grant.
REQ-028 An access or pending rvalid interrupted by reset SHALL be dropped and not replayed.

Structure
REQ-029 The shared package SHALL hold the state encoding (IDLE, ACCESS), the owner-id encoding and the default ADDRESS_WIDTH constant.
REQ-030 A single sub-module, rr_pick2, SHALL hold the two-way round-robin choice and its pointer; all other logic lives in ram_arbiter.

Verification
REQ-031 Single read: m0 read of addr 0x0010, preloaded 0xBEEF -> m0_ack in cycle 2, m0_rvalid with m0_rdata=0xBEEF in cycle 3, m1 outputs quiet.
REQ-032 Byte write: m1 write we=01, addr 0x0020, wdata 0x12AB over word 0x5566 -> m1_ack; a later read returns 0x55AB; no m1_rvalid for the write.
REQ-033 Contention: m0 and m1 both request continuously from reset -> grants alternate m0, m1, m0, m1 with acks 2 cycles apart, never simultaneous.
REQ-034 Late request: m1_req rises during an m0 ACCESS cycle -> m1 granted in the next IDLE, acked 2 cycles after the m0 ack.
REQ-035 Reset mid-read: rst_n low in the ACCESS cycle of an m0 read -> no m0_rvalid follows, all outputs 0, and the first contended grant after release goes to m0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ram_arbiter_pkg                                            |
// | Purpose : Shared types and constants for the two-port RAM arbiter:   |
// |           FSM state encoding, owner-id encoding, default widths.     |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package ram_arbiter_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 14;
  localparam int DATA_WIDTH            = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_t;

endpackage : ram_arbiter_pkg
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ram_arbiter_if                                             |
// | Purpose : One requester port of the RAM arbiter.                     |
// | Signals : req    - access pending, held until ack                    |
// |           we     - byte write enables (2'b00 = read)                 |
// |           addr   - word address                                      |
// |           wdata  - write data                                        |
// |           ack    - one-cycle pulse when the access is issued         |
// |           rvalid - one-cycle pulse when rdata holds read data        |
// |           rdata  - read data, held between rvalid pulses             |
// | Modports: master (requester side), slave (arbiter side)              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) ();

  logic                     req;
  logic [1:0]               we;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     ack;
  logic                     rvalid;
  logic [DATA_WIDTH-1:0]    rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rvalid, rdata
  );

endinterface : ram_arbiter_if
`default_nettype wire

// File: rtl/ram_arbiter_rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_pick2                                                   |
// | Purpose : Two-way round-robin choice. With both requests present the |
// |           requester not granted most recently wins; with a single    |
// |           request that requester wins regardless of history.         |
// | Ports   : clk, rst_n - clock, async active-low reset                 |
// |           req[1:0]   - request vector (bit i = requester i)          |
// |           take       - a grant is being consumed this cycle          |
// |           valid      - at least one request present                  |
// |           grant      - chosen requester                              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       valid,
  output owner_t     grant
);

  owner_t last_grant;

  always_comb begin
    valid = |req;
    grant = OWNER_M0;
    if (req == 2'b11) begin
      grant = (last_grant == OWNER_M0) ? OWNER_M1 : OWNER_M0;
    end else if (req[1]) begin
      grant = OWNER_M1;
    end
  end

  // Reset to "m1 granted last" so the first contended grant goes to m0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= OWNER_M1;
    end else if (take && valid) begin
      last_grant <= grant;
    end
  end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ram_arbiter                                                |
// | Purpose : Shares one synchronous 16-bit RAM between two requesters.  |
// |           IDLE picks a requester (round-robin) and registers its     |
// |           request; ACCESS drives the RAM and pulses the owner's ack; |
// |           reads return rvalid/rdata the cycle after ACCESS.          |
// | Ports   : clk, rst_n - clock, async active-low reset                 |
// |           m0, m1     - requester ports (slave modport)               |
// |           ram_we     - RAM byte write enables (0 outside ACCESS)     |
// |           ram_addr   - RAM word address (held outside ACCESS)        |
// |           ram_data   - RAM write data (held outside ACCESS)          |
// |           ram_q      - RAM read data, one cycle after address        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ram_arbiter_if.slave             m0,
  ram_arbiter_if.slave             m1,
  output logic [1:0]               ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_data,
  input  logic [DATA_WIDTH-1:0]    ram_q
);

  state_t                   state;
  owner_t                   owner;
  logic                     is_read;
  logic                     ack0_q;
  logic                     ack1_q;
  logic                     rv0_q;
  logic                     rv1_q;
  logic [DATA_WIDTH-1:0]    hold0;
  logic [DATA_WIDTH-1:0]    hold1;

  logic                     pick_valid;
  owner_t                   pick;
  logic [1:0]               sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;
  logic                     take;

  // Requests are only looked at in IDLE, so anything raised during ACCESS
  // waits for the next IDLE cycle.
  assign take = (state == ST_IDLE);

  rr_pick2 u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({m1.req, m0.req}),
    .take  (take),
    .valid (pick_valid),
    .grant (pick)
  );

  always_comb begin
    sel_we    = m0.we;
    sel_addr  = m0.addr;
    sel_wdata = m0.wdata;
    if (pick == OWNER_M1) begin
      sel_we    = m1.we;
      sel_addr  = m1.addr;
      sel_wdata = m1.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= OWNER_M0;
      is_read  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      hold0    <= '0;
      hold1    <= '0;
      ram_we   <= 2'b00;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      // Capture the returned word so rdata keeps it after the rvalid pulse.
      if (rv0_q) hold0 <= ram_q;
      if (rv1_q) hold1 <= ram_q;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state    <= ST_ACCESS;
            owner    <= pick;
            is_read  <= (sel_we == 2'b00);
            ram_we   <= sel_we;
            ram_addr <= sel_addr;
            ram_data <= sel_wdata;
            ack0_q   <= (pick == OWNER_M0);
            ack1_q   <= (pick == OWNER_M1);
          end
        end
        ST_ACCESS: begin
          state  <= ST_IDLE;
          ram_we <= 2'b00;
          if (is_read) begin
            rv0_q <= (owner == OWNER_M0);
            rv1_q <= (owner == OWNER_M1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          ram_we <= 2'b00;
        end
      endcase
    end
  end

  // ram_q is already valid in the rvalid cycle, so it is forwarded directly
  // then; the held copy covers every other cycle.
  assign m0.ack    = ack0_q;
  assign m1.ack    = ack1_q;
  assign m0.rvalid = rv0_q;
  assign m1.rvalid = rv1_q;
  assign m0.rdata  = rv0_q ? ram_q : hold0;
  assign m1.rdata  = rv1_q ? ram_q : hold1;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ram_arbiter                                             |
// | Purpose : Self-checking bench for ram_arbiter: directed scenarios    |
// |           followed by random two-requester traffic, compared against |
// |           a cycle-timeline reference model and a shadow memory.      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_ram_arbiter;

  localparam int AW   = 14;
  localparam int MAXC = 4096;
  localparam int NW   = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_data;
  logic [15:0]   ram_q = 16'h0000;

  ram_arbiter_if #(.ADDRESS_WIDTH(AW)) m0_bus ();
  ram_arbiter_if #(.ADDRESS_WIDTH(AW)) m1_bus ();

  ram_arbiter #(.ADDRESS_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0       (m0_bus),
    .m1       (m1_bus),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_q    (ram_q)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous, q valid one cycle after the address.
  logic [15:0] ram_mem [NW];
  always @(posedge clk) begin
    if (ram_we[0]) ram_mem[ram_addr][7:0]  <= ram_data[7:0];
    if (ram_we[1]) ram_mem[ram_addr][15:8] <= ram_data[15:8];
    ram_q <= ram_mem[ram_addr];
  end

  // ---------------- reference model state ----------------
  logic [15:0]   ref_mem [NW];
  logic [1:0]    e_ack  [MAXC];
  logic [1:0]    e_rv   [MAXC];
  logic [15:0]   e_rd   [MAXC];
  logic [1:0]    e_we   [MAXC];
  logic          e_acc  [MAXC];
  logic [AW-1:0] e_addr [MAXC];
  logic [15:0]   e_data [MAXC];
  logic [15:0]   hold0, hold1;
  int            cyc;
  int            next_free;
  int            last_w;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_model();
    for (int j = cyc; j < MAXC; j++) begin
      e_ack[j] = 2'b00; e_rv[j] = 2'b00; e_rd[j] = 16'h0;
      e_we[j] = 2'b00; e_acc[j] = 1'b0; e_addr[j] = '0; e_data[j] = 16'h0;
    end
    next_free = cyc;
    last_w    = 1;   // m1 counts as most recent, so m0 wins the first tie
    hold0     = 16'h0;
    hold1     = 16'h0;
  endtask

  // Decide what the requests present in cycle 'cyc' must produce:
  // a grant in cycle t shows as ack at t+1 and rvalid at t+2, and the
  // arbiter cannot grant again until t+2.
  task automatic model_eval();
    int            w;
    logic [1:0]    r, we;
    logic [AW-1:0] a;
    logic [15:0]   d;
    if (!rst_n) return;
    r = {m1_bus.req, m0_bus.req};
    if (cyc >= next_free && r != 2'b00 && cyc + 2 < MAXC) begin
      if (r == 2'b11) w = 1 - last_w;
      else            w = r[1] ? 1 : 0;
      last_w = w;
      if (w == 1) begin we = m1_bus.we; a = m1_bus.addr; d = m1_bus.wdata; end
      else        begin we = m0_bus.we; a = m0_bus.addr; d = m0_bus.wdata; end
      e_ack[cyc+1][w] = 1'b1;
      e_acc[cyc+1]    = 1'b1;
      e_we[cyc+1]     = we;
      e_addr[cyc+1]   = a;
      e_data[cyc+1]   = d;
      if (we == 2'b00) begin
        e_rv[cyc+2][w] = 1'b1;
        e_rd[cyc+2]    = ref_mem[a];
      end else begin
        if (we[0]) ref_mem[a][7:0]  = d[7:0];
        if (we[1]) ref_mem[a][15:8] = d[15:8];
      end
      next_free = cyc + 2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("ack0",    m0_bus.ack,    e_ack[cyc][0]);
    chk("ack1",    m1_bus.ack,    e_ack[cyc][1]);
    chk("rvalid0", m0_bus.rvalid, e_rv[cyc][0]);
    chk("rvalid1", m1_bus.rvalid, e_rv[cyc][1]);
    if (e_rv[cyc][0]) hold0 = e_rd[cyc];
    if (e_rv[cyc][1]) hold1 = e_rd[cyc];
    chk("rdata0",  m0_bus.rdata,  hold0);
    chk("rdata1",  m1_bus.rdata,  hold1);
    chk("ram_we",  ram_we,        e_we[cyc]);
    if (e_acc[cyc]) begin
      chk("ram_addr", ram_addr, e_addr[cyc]);
      if (e_we[cyc] != 2'b00) chk("ram_data", ram_data, e_data[cyc]);
    end
  endtask

  task automatic cyc_go();
    model_eval();
    tick();
  endtask

  task automatic set_m0(input logic rq, input logic [1:0] we, input logic [AW-1:0] a, input logic [15:0] d);
    m0_bus.req = rq; m0_bus.we = we; m0_bus.addr = a; m0_bus.wdata = d;
  endtask

  task automatic set_m1(input logic rq, input logic [1:0] we, input logic [AW-1:0] a, input logic [15:0] d);
    m1_bus.req = rq; m1_bus.we = we; m1_bus.addr = a; m1_bus.wdata = d;
  endtask

  // Random requester behaviour: hold until ack, then maybe re-request.
  task automatic rand_req(input logic cur, input logic acked, output logic nxt, output logic fresh);
    fresh = 1'b0;
    if (cur && acked)  begin nxt = ($urandom % 2) == 0; fresh = nxt; end
    else if (!cur)     begin nxt = ($urandom % 3) == 0; fresh = nxt; end
    else               nxt = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int own_q[$];
    int at_q[$];
    int rel;
    logic nxt, fresh;
    logic [1:0] rwe;

    rst_n = 1'b0;
    cyc   = 0;
    set_m0(1'b0, 2'b00, '0, 16'h0);
    set_m1(1'b0, 2'b00, '0, 16'h0);
    for (int i = 0; i < NW; i++) begin
      ram_mem[i] = 16'(i * 16'h1357) ^ 16'hA5A5;
      ref_mem[i] = 16'(i * 16'h1357) ^ 16'hA5A5;
    end
    ram_mem[14'h0010] = 16'hBEEF; ref_mem[14'h0010] = 16'hBEEF;
    ram_mem[14'h0020] = 16'h5566; ref_mem[14'h0020] = 16'h5566;
    reset_model();

    // Reset state
    repeat (3) cyc_go();
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);
    rst_n = 1'b1;
    reset_model();

    // Single read of 0x0010
    set_m0(1'b1, 2'b00, 14'h0010, 16'h0);
    cyc_go();
    chk("rd_ack_c2", m0_bus.ack, 1);
    set_m0(1'b0, 2'b00, 14'h0010, 16'h0);
    cyc_go();
    chk("rd_rvalid_c3", m0_bus.rvalid, 1);
    chk("rd_data_c3",   m0_bus.rdata,  16'hBEEF);
    chk("rd_m1_quiet",  {m1_bus.ack, m1_bus.rvalid}, 0);

    // Low-byte write over 0x5566, then read back
    set_m1(1'b1, 2'b01, 14'h0020, 16'h12AB);
    cyc_go();
    chk("bw_ack", m1_bus.ack, 1);
    chk("bw_ram_we", ram_we, 2'b01);
    set_m1(1'b0, 2'b00, 14'h0020, 16'h0);
    cyc_go();
    chk("bw_no_rvalid", m1_bus.rvalid, 0);
    set_m1(1'b1, 2'b00, 14'h0020, 16'h0);
    cyc_go();
    set_m1(1'b0, 2'b00, 14'h0020, 16'h0);
    cyc_go();
    chk("bw_readback", m1_bus.rdata, 16'h55AB);

    // Late request raised during an m0 ACCESS cycle
    cyc_go();
    set_m0(1'b1, 2'b00, 14'h0003, 16'h0);
    cyc_go();
    chk("late_m0_ack", m0_bus.ack, 1);
    set_m0(1'b0, 2'b00, 14'h0003, 16'h0);
    set_m1(1'b1, 2'b00, 14'h0005, 16'h0);
    cyc_go();
    chk("late_not_yet", m1_bus.ack, 0);
    cyc_go();
    chk("late_m1_ack", m1_bus.ack, 1);
    set_m1(1'b0, 2'b00, 14'h0005, 16'h0);
    repeat (2) cyc_go();

    // Reset in the ACCESS cycle of an m0 read
    set_m0(1'b1, 2'b00, 14'h0010, 16'h0);
    cyc_go();
    chk("mr_ack", m0_bus.ack, 1);
    rst_n = 1'b0;
    set_m0(1'b0, 2'b00, 14'h0010, 16'h0);
    #1;
    chk("mr_outs_zero", {m0_bus.ack, m0_bus.rvalid, m1_bus.ack, m1_bus.rvalid, ram_we}, 0);
    chk("mr_addr_zero", ram_addr, 0);
    chk("mr_rdata_zero", m0_bus.rdata, 0);
    reset_model();
    cyc_go();
    chk("mr_no_rvalid", m0_bus.rvalid, 0);
    rst_n = 1'b1;
    reset_model();

    // Continuous contention straight out of reset
    rel = cyc;
    set_m0(1'b1, 2'b00, 14'h0010, 16'h0);
    set_m1(1'b1, 2'b00, 14'h0020, 16'h0);
    for (int k = 0; k < 8; k++) begin
      cyc_go();
      if (m0_bus.ack) begin own_q.push_back(0); at_q.push_back(cyc); end
      if (m1_bus.ack) begin own_q.push_back(1); at_q.push_back(cyc); end
    end
    chk("cont_count", own_q.size(), 4);
    for (int k = 0; k < own_q.size(); k++) begin
      chk("cont_owner", own_q[k], k % 2);
      chk("cont_cycle", at_q[k] - rel, 1 + 2 * k);
    end
    set_m0(1'b0, 2'b00, '0, 16'h0);
    set_m1(1'b0, 2'b00, '0, 16'h0);
    repeat (3) cyc_go();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      rand_req(m0_bus.req, m0_bus.ack, nxt, fresh);
      m0_bus.req = nxt;
      if (fresh) begin
        rwe = ($urandom % 2) ? 2'b00 : 2'($urandom_range(1, 3));
        set_m0(1'b1, rwe, AW'($urandom_range(0, 15)), 16'($urandom));
      end
      rand_req(m1_bus.req, m1_bus.ack, nxt, fresh);
      m1_bus.req = nxt;
      if (fresh) begin
        rwe = ($urandom % 2) ? 2'b00 : 2'($urandom_range(1, 3));
        set_m1(1'b1, rwe, AW'($urandom_range(0, 15)), 16'($urandom));
      end
      cyc_go();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ram_arbiter
`default_nettype wire
